// File: rtl/dcache_pkg.sv
// dcache_pkg: shared widths, FSM states and line type for the direct-mapped data cache.
package dcache_pkg;
    localparam int NUM_LINES      = 32;
    localparam int WORDS_PER_LINE = 8;
    localparam int ADDR_W         = 32;
    localparam int IDX_W          = $clog2(NUM_LINES);
    localparam int WORD_W         = $clog2(WORDS_PER_LINE);
    localparam int OFF_W          = WORD_W + 2;
    localparam int TAG_W          = ADDR_W - IDX_W - OFF_W;
    localparam int LINE_W         = 32 * WORDS_PER_LINE;

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [IDX_W-1:0]  idx_t;
    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL} state_t;
endpackage

// File: rtl/dcache_if.sv
// dcache_if: CPU-side and memory-side signals of the data cache; slave = cache view.
interface dcache_if;
    import dcache_pkg::*;
    logic [ADDR_W-1:0] cpu_addr_i;
    logic [31:0]       cpu_wdata_i;
    logic              cpu_rd_i;
    logic              cpu_wr_i;
    logic [31:0]       cpu_rdata_o;
    logic              cpu_stall_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    line_t             mem_wdata_o;
    line_t             mem_rdata_i;
    logic              mem_ack_i;

    modport slave (
        input  cpu_addr_i, cpu_wdata_i, cpu_rd_i, cpu_wr_i, mem_rdata_i, mem_ack_i,
        output cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
    modport master (
        output cpu_addr_i, cpu_wdata_i, cpu_rd_i, cpu_wr_i, mem_rdata_i, mem_ack_i,
        input  cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/dcache_sram.sv
// dcache_sram: tag/valid/dirty/data arrays, asynchronous read, synchronous write.
module dcache_sram
    import dcache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  idx_t              idx_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic [31:0]       wdata_i,
    input  logic              word_we_i,
    input  logic              fill_i,
    input  tag_t              fill_tag_i,
    input  line_t             fill_line_i,
    input  logic              clr_dirty_i,
    output tag_t              tag_o,
    output logic              valid_o,
    output logic              dirty_o,
    output line_t             line_o
);
    tag_t                 tag_q  [NUM_LINES];
    line_t                data_q [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q, dirty_q;

    assign tag_o   = tag_q[idx_i];
    assign line_o  = data_q[idx_i];
    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];

    // Payload arrays are deliberately left out of reset; only valid/dirty are cleared.
    always_ff @(posedge clk_i) begin
        if (fill_i) begin
            tag_q[idx_i]  <= fill_tag_i;
            data_q[idx_i] <= fill_line_i;
        end else if (word_we_i) begin
            data_q[idx_i][{word_i, 5'd0} +: 32] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (word_we_i) begin
            dirty_q[idx_i] <= 1'b1;
        end else if (clr_dirty_i) begin
            dirty_q[idx_i] <= 1'b0;
        end
    end
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate L1 D-cache; FSM, hit logic, request registers.
module dcache_ctrl
    import dcache_pkg::*;
(
    input logic     clk_i,
    input logic     rst_i,
    dcache_if.slave bus
);
    state_t                   state_q, state_d;
    logic                     req_q, req_d, we_q, we_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    line_t                    wdata_q, wdata_d;
    logic [ADDR_W-1:OFF_W]    maddr_q, maddr_d;
    tag_t                     tag, vtag;
    idx_t                     idx, sidx;
    logic [WORD_W-1:0]        word;
    logic                     valid, dirty, hit, access, ack, fill, clr_dirty, word_we, unused_ok;
    line_t                    line;

    assign tag       = bus.cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign idx       = bus.cpu_addr_i[OFF_W +: IDX_W];
    assign word      = bus.cpu_addr_i[2 +: WORD_W];
    assign unused_ok = ^bus.cpu_addr_i[1:0];
    // Outside IDLE the line being serviced is addressed from the latched miss address.
    assign sidx      = (state_q == IDLE) ? idx : maddr_q[OFF_W +: IDX_W];
    assign hit       = valid && vtag == tag;
    assign access    = bus.cpu_rd_i || bus.cpu_wr_i;
    assign ack       = bus.mem_ack_i && req_q;
    assign word_we   = bus.cpu_wr_i && hit && state_q == IDLE;

    assign bus.cpu_stall_o = access && (!hit || state_q != IDLE);
    assign bus.cpu_rdata_o = (bus.cpu_rd_i && !bus.cpu_stall_o) ? line[{word, 5'd0} +: 32] : 32'd0;
    assign bus.mem_req_o   = req_q;
    assign bus.mem_we_o    = we_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;

    dcache_sram u_sram (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .idx_i       (sidx),
        .word_i      (word),
        .wdata_i     (bus.cpu_wdata_i),
        .word_we_i   (word_we),
        .fill_i      (fill),
        .fill_tag_i  (maddr_q[ADDR_W-1 -: TAG_W]),
        .fill_line_i (bus.mem_rdata_i),
        .clr_dirty_i (clr_dirty),
        .tag_o       (vtag),
        .valid_o     (valid),
        .dirty_o     (dirty),
        .line_o      (line)
    );

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        maddr_d   = maddr_q;
        fill      = 1'b0;
        clr_dirty = 1'b0;
        case (state_q)
            IDLE: if (access && !hit) begin
                maddr_d = bus.cpu_addr_i[ADDR_W-1:OFF_W];
                req_d   = 1'b1;
                we_d    = valid && dirty;
                addr_d  = {(valid && dirty) ? vtag : tag, idx, {OFF_W{1'b0}}};
                wdata_d = line;
                state_d = (valid && dirty) ? WRITEBACK : ALLOCATE;
            end
            WRITEBACK: if (ack) begin
                clr_dirty = 1'b1;
                req_d     = 1'b0;
                state_d   = ALLOCATE;
            end
            // Coming from WRITEBACK the request is low for one cycle, then re-issued as a read.
            ALLOCATE: if (ack) begin
                fill    = 1'b1;
                req_d   = 1'b0;
                state_d = REFILL;
            end else if (!req_q) begin
                req_d  = 1'b1;
                we_d   = 1'b0;
                addr_d = {maddr_q, {OFF_W{1'b0}}};
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            maddr_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            maddr_q <= maddr_d;
        end
    end
endmodule
